// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL power-up/recovery sequencer with lock qualification, retry budget and latched fault.
module pll_reset_ctrl #(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       req_reset,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lost_cnt
);
  typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry, retry_nxt;
  logic [7:0]       lost_nxt;
  logic [1:0]       sync;
  logic             lock_s;
  assign lock_s = sync[1];
  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state     <= RST_PLL;
      cnt       <= '0;
      retry     <= '0;
      lost_cnt  <= '0;
      sync      <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      retry     <= retry_nxt;
      lost_cnt  <= lost_nxt;
      sync      <= {sync[0], locked};
      pll_rst   <= nxt == RST_PLL;
      sys_rst_n <= nxt == RUN;
      ready     <= nxt == RUN;
      fault     <= nxt == FAULT;
    end
  end
  // Counter defaults to zero, so every state change restarts it and it can never wrap.
  always_comb begin
    nxt       = state;
    cnt_nxt   = '0;
    retry_nxt = retry;
    lost_nxt  = lost_cnt;
    if (req_reset) begin
      nxt       = RST_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        RST_PLL:
          if (cnt == RST_LAST) nxt = WAIT_LOCK;
          else cnt_nxt = cnt + ONE;
        WAIT_LOCK:
          if (lock_s) nxt = STABLE;
          else if (cnt == TO_LAST) begin
            nxt       = (retry == MAX_R) ? FAULT : RST_PLL;
            retry_nxt = (retry == MAX_R) ? retry : retry + 4'd1;
          end else cnt_nxt = cnt + ONE;
        STABLE:
          if (!lock_s) nxt = WAIT_LOCK;
          else if (cnt == STB_LAST) nxt = RUN;
          else cnt_nxt = cnt + ONE;
        RUN:
          if (!lock_s) begin
            nxt       = RST_PLL;
            retry_nxt = '0;
            lost_nxt  = (&lost_cnt) ? lost_cnt : lost_cnt + 8'd1;
          end
        FAULT:   nxt = FAULT;
        default: nxt = RST_PLL;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: directed test-plan scenarios plus random lock/request traffic against a phase/age reference model.
module tb_pll_reset_ctrl;
  localparam int RST_PULSE = 4, LOCK_STABLE = 8, LOCK_TIMEOUT = 16, MAX_RETRY = 2, CNT_W = 8;
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FLT = 4;
  logic clkin = 0, rst_n = 0, locked = 0, req_reset = 0;
  logic pll_rst, sys_rst_n, ready, fault;
  logic [7:0] lost_cnt;
  int n_tests = 0, n_fail = 0;
  int m_ph = P_RST, m_age = 0, m_tries = 1, m_lost = 0;
  bit lq[$] = '{0, 0};

  pll_reset_ctrl #(.RST_PULSE(RST_PULSE), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
                   .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clkin(clkin), .rst_n(rst_n), .locked(locked), .req_reset(req_reset),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault), .lost_cnt(lost_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: lock seen through a two-sample delay line, phases timed by elapsed cycles, attempts counted from 1.
  task automatic model();
    bit ls;
    if (!rst_n) begin
      m_ph = P_RST; m_age = 0; m_tries = 1; m_lost = 0; lq = '{0, 0};
      return;
    end
    ls = lq.pop_front();
    lq.push_back(locked);
    if (req_reset) begin
      m_ph = P_RST; m_age = 0; m_tries = 1;
      return;
    end
    case (m_ph)
      P_RST: begin
        m_age++;
        if (m_age == RST_PULSE) begin m_ph = P_WAIT; m_age = 0; end
      end
      P_WAIT:
        if (ls) begin m_ph = P_STAB; m_age = 0; end
        else begin
          m_age++;
          if (m_age == LOCK_TIMEOUT) begin
            m_age = 0;
            if (m_tries == 1 + MAX_RETRY) m_ph = P_FLT;
            else begin m_tries++; m_ph = P_RST; end
          end
        end
      P_STAB:
        if (!ls) begin m_ph = P_WAIT; m_age = 0; end
        else begin
          m_age++;
          if (m_age == LOCK_STABLE) begin m_ph = P_RUN; m_age = 0; end
        end
      P_RUN:
        if (!ls) begin
          m_lost = (m_lost < 255) ? m_lost + 1 : 255;
          m_tries = 1; m_ph = P_RST; m_age = 0;
        end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clkin);
    model();
    #1;
    chk("pll_rst", pll_rst, m_ph == P_RST);
    chk("sys_rst_n", sys_rst_n, m_ph == P_RUN);
    chk("ready", ready, m_ph == P_RUN);
    chk("fault", fault, m_ph == P_FLT);
    chk("lost_cnt", lost_cnt, m_lost);
    @(negedge clkin);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin tick(); n++; end
    chk("ready_wait", ready, 1);
  endtask

  task automatic wait_pll_low();
    int n = 0;
    while (pll_rst && n < 200) begin tick(); n++; end
    chk("pll_low_wait", pll_rst, 0);
  endtask

  task automatic measure_lat(input string tag);
    int lat = 0;
    while (!sys_rst_n && lat < 100) begin tick(); lat++; end
    chk(tag, lat, LOCK_STABLE + 2);
  endtask

  task automatic pulses_to_fault(input string tag);
    int n = 0, p;
    logic prev;
    p = pll_rst ? 1 : 0;
    prev = pll_rst;
    while (!fault && n < 300) begin
      tick();
      n++;
      if (pll_rst && !prev) p++;
      prev = pll_rst;
    end
    chk({tag, "_fault"}, fault, 1);
    chk({tag, "_pulses"}, p, 1 + MAX_RETRY);
  endtask

  initial begin
    int n, hold;
    // 1: power-up and normal lock
    repeat (3) tick();
    rst_n = 1;
    n = 1;
    while (pll_rst && n < 50) begin tick(); if (pll_rst) n++; end
    chk("pwrup_pulse", n, RST_PULSE);
    repeat (5) tick();
    locked = 1;
    tick();
    measure_lat("pwrup_lat");
    chk("pwrup_lost", lost_cnt, 0);
    // 2: lock never arrives, then fault cleared by request
    locked = 0; req_reset = 1;
    tick();
    req_reset = 0;
    pulses_to_fault("nolock");
    repeat (30) tick();
    chk("fault_hold", fault, 1);
    chk("fault_pll", pll_rst, 0);
    req_reset = 1;
    tick();
    req_reset = 0;
    chk("clr_fault", fault, 0);
    chk("clr_pll", pll_rst, 1);
    // 3: lock chatter while stabilising
    wait_pll_low();
    locked = 1;
    repeat (6) tick();
    locked = 0;
    repeat (2) tick();
    chk("chatter_hold", sys_rst_n, 0);
    locked = 1;
    tick();
    measure_lat("chatter_lat");
    // 4: lock loss in RUN
    locked = 0;
    repeat (2) tick();
    chk("loss_still_run", ready, 1);
    tick();
    chk("loss_sys", sys_rst_n, 0);
    chk("loss_pll", pll_rst, 1);
    chk("loss_cnt", lost_cnt, 1);
    // 5a: request coincides with lock loss
    locked = 1;
    wait_ready();
    locked = 0;
    repeat (2) tick();
    req_reset = 1;
    tick();
    req_reset = 0;
    chk("simul_pll", pll_rst, 1);
    chk("simul_lost", lost_cnt, 1);
    // 4 cont.: saturation
    repeat (299) begin
      locked = 1;
      wait_ready();
      locked = 0;
      repeat (3) tick();
    end
    chk("lost_sat", lost_cnt, 255);
    // 5b: rst_n wins over req_reset
    rst_n = 0; req_reset = 1;
    tick();
    rst_n = 1; req_reset = 0;
    chk("rst_pll", pll_rst, 1);
    chk("rst_sys", sys_rst_n, 0);
    chk("rst_fault", fault, 0);
    chk("rst_lost", lost_cnt, 0);
    // 6: reset mid-WAIT_LOCK restores the full retry budget
    wait_pll_low();
    repeat (10) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midrst_pll", pll_rst, 1);
    pulses_to_fault("midrst");
    // random traffic
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        locked = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 40);
      end
      hold--;
      req_reset = ($urandom_range(0, 149) == 0);
      rst_n = ($urandom_range(0, 249) != 0);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
